// File: rtl/tohost_pkg.sv
// Shared definitions for the tohost test-status responder.
// Holds the state encoding (also the externally visible status code),
// default bus addresses and the status-window word offsets.
package tohost_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  // Values double as state_code and the status-window state word.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_ERROR   = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] TOHOST_ADDR_D = 32'd32;
  localparam logic [ADDR_W-1:0] HALF_ADDR_D   = 32'd16;
  localparam logic [ADDR_W-1:0] STATUS_ADDR_D = 32'd48;

  localparam logic [ADDR_W-1:0] OFF_STATE  = 32'd0;
  localparam logic [ADDR_W-1:0] OFF_CYCLES = 32'd4;
  localparam logic [ADDR_W-1:0] OFF_HALF   = 32'd8;
  localparam logic [ADDR_W-1:0] OFF_ERR    = 32'd12;

endpackage

// File: rtl/tohost_monitor_if.sv
// Data-memory bus between the RV32I core and the tohost monitor.
//   MemWrite  : store strobe (core -> monitor)
//   DataAdr   : byte address (core -> monitor)
//   WriteData : store data (core -> monitor)
//   ReadData  : combinational status readback (monitor -> core)
interface tohost_monitor_if;
  import tohost_pkg::*;

  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;

  modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
  modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock
//   clr : synchronous clear, dominates inc
//   inc : count enable; holds at all-ones once reached
//   q   : registered count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/tohost_monitor.sv
// Test-status responder on the RV32I data-memory write bus.
// Watches stores: tohost word ends the test (1 pass, 0 fail, else error),
// the half address is permitted traffic, anything else is an error.
// A watchdog forces TIMEOUT after TIMEOUT cycles in RUN (0 disables).
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of the data-memory bus (ReadData combinational)
//   done, pass : terminal / passed flags
//   state_code : RUN=0 PASS=1 FAIL=2 ERROR=3 TIMEOUT=4
//   cycles     : saturating RUN cycle count
//   half_count : saturating count of half-address stores
//   last_half  : low half of the most recent half-address store
//   err_addr, err_data : first offending store
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = TOHOST_ADDR_D,
  parameter logic [ADDR_W-1:0] HALF_ADDR   = HALF_ADDR_D,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = STATUS_ADDR_D,
  parameter int unsigned       TIMEOUT     = 100000,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  tohost_monitor_if.slave   bus,
  output logic              done,
  output logic              pass,
  output logic [2:0]        state_code,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  half_count,
  output logic [HALF_W-1:0] last_half,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
);

  // Count value seen at the edge on which the watchdog fires.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic   cyc_inc_c, half_inc_c, err_cap_c;

  // Next-state decode: stores only matter while in RUN.
  always_comb begin
    state_d    = state_q;
    cyc_inc_c  = 1'b0;
    half_inc_c = 1'b0;
    err_cap_c  = 1'b0;
    if (state_q == ST_RUN) begin
      cyc_inc_c = 1'b1;
      if (bus.MemWrite) begin
        if (bus.DataAdr == TOHOST_ADDR) begin
          if (bus.WriteData == 32'd1) begin
            state_d = ST_PASS;
          end else if (bus.WriteData == 32'd0) begin
            state_d = ST_FAIL;
          end else begin
            state_d   = ST_ERROR;
            err_cap_c = 1'b1;
          end
        end else if (bus.DataAdr == HALF_ADDR) begin
          half_inc_c = 1'b1;
        end else begin
          state_d   = ST_ERROR;
          err_cap_c = 1'b1;
        end
      end
      // A terminating store on the expiry edge wins over the watchdog.
      if ((TIMEOUT != 0) && (state_d == ST_RUN) && (cycles == WD_LAST)) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // State, flags and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      done      <= 1'b0;
      pass      <= 1'b0;
      last_half <= '0;
      err_addr  <= '0;
      err_data  <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_d != ST_RUN);
      pass    <= (state_d == ST_PASS);
      if (half_inc_c) begin
        last_half <= bus.WriteData[HALF_W-1:0];
      end
      if (err_cap_c) begin
        err_addr <= bus.DataAdr;
        err_data <= bus.WriteData;
      end
    end
  end

  assign state_code = state_q;

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk (clk),
    .clr (reset),
    .inc (cyc_inc_c),
    .q   (cycles)
  );

  sat_counter #(.W(CNT_W)) u_half (
    .clk (clk),
    .clr (reset),
    .inc (half_inc_c),
    .q   (half_count)
  );

  // Status window readback; zero everywhere else.
  always_comb begin
    bus.ReadData = '0;
    if (bus.DataAdr == STATUS_ADDR + OFF_STATE) begin
      bus.ReadData = {29'b0, state_q};
    end else if (bus.DataAdr == STATUS_ADDR + OFF_CYCLES) begin
      bus.ReadData = 32'(cycles);
    end else if (bus.DataAdr == STATUS_ADDR + OFF_HALF) begin
      bus.ReadData = 32'(half_count);
    end else if (bus.DataAdr == STATUS_ADDR + OFF_ERR) begin
      bus.ReadData = err_addr;
    end
  end

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: two instances (watchdog 50 / 32-bit counters,
// and watchdog off / 4-bit counters) share one stimulus stream.
module tb_tohost_monitor;

  localparam int unsigned TMO0 = 50;
  localparam int unsigned CW1  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  tohost_monitor_if bus0 ();
  tohost_monitor_if bus1 ();

  logic        done0, pass0, done1, pass1;
  logic [2:0]  sc0, sc1;
  logic [31:0] cyc0, half0;
  logic [CW1-1:0] cyc1, half1;
  logic [15:0] last0, last1;
  logic [31:0] ea0, ed0, ea1, ed1;

  tohost_monitor #(.TIMEOUT(TMO0), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .done(done0), .pass(pass0),
    .state_code(sc0), .cycles(cyc0), .half_count(half0), .last_half(last0),
    .err_addr(ea0), .err_data(ed0)
  );

  tohost_monitor #(.TIMEOUT(0), .CNT_W(CW1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .done(done1), .pass(pass1),
    .state_code(sc1), .cycles(cyc1), .half_count(half1), .last_half(last1),
    .err_addr(ea1), .err_data(ed1)
  );

  // Reference state: what the status registers should hold after an edge.
  typedef struct {
    int              st;
    longint unsigned cyc;
    longint unsigned half;
    logic [15:0]     last;
    logic [31:0]     ea;
    logic [31:0]     ed;
  } m_t;

  m_t m0, m1;
  m_t q0[$];
  m_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic m_t mstep(m_t s, bit rst, bit we, logic [31:0] adr,
                               logic [31:0] dat, longint unsigned tmo,
                               longint unsigned maxv);
    m_t n = s;
    int term = -1;
    if (rst) begin
      n.st = 0; n.cyc = 0; n.half = 0; n.last = '0; n.ea = '0; n.ed = '0;
      return n;
    end
    if (s.st != 0) return n;
    if (we) begin
      if (adr == 32'd32) term = (dat == 32'd1) ? 1 : ((dat == 32'd0) ? 2 : 3);
      else if (adr == 32'd16) begin
        if (n.half < maxv) n.half++;
        n.last = dat[15:0];
      end else term = 3;
      if (term == 3) begin n.ea = adr; n.ed = dat; end
    end
    if (n.cyc < maxv) n.cyc++;
    if (term >= 0) n.st = term;
    else if (tmo != 0 && s.cyc == tmo - 1) n.st = 4;
    return n;
  endfunction

  function automatic logic [31:0] mread(m_t s, logic [31:0] adr);
    case (adr)
      32'd48:  return 32'(s.st);
      32'd52:  return 32'(s.cyc);
      32'd56:  return 32'(s.half);
      32'd60:  return s.ea;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, queue the expectation.
  task automatic step(input bit rst, input bit we, input logic [31:0] adr, input logic [31:0] dat);
    reset = rst;
    bus0.MemWrite = we; bus0.DataAdr = adr; bus0.WriteData = dat;
    bus1.MemWrite = we; bus1.DataAdr = adr; bus1.WriteData = dat;
    m0 = mstep(m0, rst, we, adr, dat, 64'(TMO0), 64'hFFFF_FFFF);
    m1 = mstep(m1, rst, we, adr, dat, 64'd0, 64'd15);
    @(posedge clk);
    #1;
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  task automatic load(input logic [31:0] adr, output logic [31:0] rd);
    bus0.MemWrite = 1'b0; bus0.DataAdr = adr;
    bus1.MemWrite = 1'b0; bus1.DataAdr = adr;
    #1;
    rd = bus0.ReadData;
  endtask

  // Scoreboard monitor: one expectation per edge, checked mid-cycle.
  initial begin
    m_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("i0.state", 32'(sc0), 32'(e.st));
        cmp("i0.done", 32'(done0), 32'(e.st != 0));
        cmp("i0.pass", 32'(pass0), 32'(e.st == 1));
        cmp("i0.cycles", cyc0, 32'(e.cyc));
        cmp("i0.half", half0, 32'(e.half));
        cmp("i0.last", 32'(last0), 32'(e.last));
        cmp("i0.eaddr", ea0, e.ea);
        cmp("i0.edata", ed0, e.ed);
        cmp("i0.rdata", bus0.ReadData, mread(e, bus0.DataAdr));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("i1.state", 32'(sc1), 32'(e.st));
        cmp("i1.done", 32'(done1), 32'(e.st != 0));
        cmp("i1.pass", 32'(pass1), 32'(e.st == 1));
        cmp("i1.cycles", 32'(cyc1), 32'(e.cyc));
        cmp("i1.half", 32'(half1), 32'(e.half));
        cmp("i1.last", 32'(last1), 32'(e.last));
        cmp("i1.eaddr", ea1, e.ea);
        cmp("i1.edata", ed1, e.ed);
        cmp("i1.rdata", bus1.ReadData, mread(e, bus1.DataAdr));
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] other_adr [5];
    logic [31:0] load_adr [7];
    int r, half_w;
    other_adr = '{32'd96, 32'd33, 32'd17, 32'd48, 32'd0};
    load_adr  = '{32'd48, 32'd52, 32'd56, 32'd60, 32'd64, 32'd49, 32'd0};
    reset = 1'b1;

    // Pass after idle
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 1, 32, 1);
    cmp("pass.state", 32'(sc0), 32'd1);
    cmp("pass.pass", 32'(pass0), 32'd1);
    cmp("pass.done", 32'(done0), 32'd1);
    cmp("pass.cycles", cyc0, 32'd6);

    // Fail
    step(1, 0, 0, 0);
    step(0, 1, 32, 0);
    cmp("fail.state", 32'(sc0), 32'd2);
    cmp("fail.pass", 32'(pass0), 32'd0);
    cmp("fail.done", 32'(done0), 32'd1);

    // Half traffic then pass
    step(1, 0, 0, 0);
    step(0, 1, 16, 32'h1234_ABCD);
    step(0, 1, 16, 32'h0000_5555);
    step(0, 1, 32, 1);
    cmp("half.count", half0, 32'd2);
    cmp("half.last", 32'(last0), 32'h5555);
    cmp("half.state", 32'(sc0), 32'd1);
    load(56, rd);
    cmp("half.rd56", rd, 32'd2);

    // Unknown store, then error is sticky
    step(1, 0, 0, 0);
    step(0, 1, 96, 7);
    cmp("err.state", 32'(sc0), 32'd3);
    cmp("err.addr", ea0, 32'd96);
    cmp("err.data", ed0, 32'd7);
    step(0, 1, 32, 1);
    cmp("err.sticky", 32'(sc0), 32'd3);
    cmp("err.keep", ea0, 32'd96);

    // Misaligned tohost address is an error
    step(1, 0, 0, 0);
    step(0, 1, 33, 1);
    cmp("mis.state", 32'(sc0), 32'd3);
    cmp("mis.addr", ea0, 32'd33);

    // Watchdog expiry
    step(1, 0, 0, 0);
    repeat (49) step(0, 0, 0, 0);
    cmp("wd.before", 32'(sc0), 32'd0);
    cmp("wd.cyc49", cyc0, 32'd49);
    step(0, 0, 0, 0);
    cmp("wd.state", 32'(sc0), 32'd4);
    cmp("wd.cyc50", cyc0, 32'd50);

    // Terminating store on the expiry edge wins
    step(1, 0, 0, 0);
    repeat (49) step(0, 0, 0, 0);
    step(0, 1, 32, 1);
    cmp("wdpass.state", 32'(sc0), 32'd1);

    // Reset mid-run, store during reset ignored
    step(1, 0, 0, 0);
    repeat (3) step(0, 1, 16, 32'hBEEF);
    step(1, 1, 32, 1);
    cmp("rst.half", half0, 32'd0);
    cmp("rst.cycles", cyc0, 32'd0);
    cmp("rst.state", 32'(sc0), 32'd0);
    load(48, rd);
    cmp("rst.rd48", rd, 32'd0);

    // Randomized episodes
    for (int ep = 0; ep < 10; ep++) begin
      half_w = (ep % 2 == 0) ? 52 : 20;
      step(1, 0, 0, 0);
      for (int c = 0; c < 70; c++) begin
        r = int'($urandom_range(0, 99));
        if (r < 45) begin
          step(0, 0, load_adr[$urandom_range(0, 6)], $urandom);
        end else if (r < 45 + half_w) begin
          step(0, 1, 16, $urandom);
        end else if (r < 99) begin
          case ($urandom_range(0, 2))
            0: step(0, 1, 32, 0);
            1: step(0, 1, 32, 1);
            default: step(0, 1, 32, $urandom | 32'h100);
          endcase
        end else begin
          step(0, 1, other_adr[$urandom_range(0, 4)], $urandom);
        end
      end
    end

    repeat (2) step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
